// File: rtl/lif_spike_monitor_if.sv
// Byte-wide valid/ready record channel from the spike monitor to its consumer.
// master drives valid/data/last; slave returns ready.
interface lif_spike_monitor_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/lif_spike_monitor.sv
// Spike monitor: counts spike rising edges per window, tracks inter-spike intervals and
// streams a {count, min_isi, last_isi} record per window over a byte channel.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   CNT_IDLE | not counting; cyc, count, have_prev, isi_cnt cleared
//   CNT_RUN  | counting spikes, cyc runs 0..window_len-1
//   OUT_IDLE | no record pending, out_valid low
//   OUT_B0   | presenting spike count
//   OUT_B1   | presenting min ISI
//   OUT_B2   | presenting last ISI with out_last
module lif_spike_monitor #(
  parameter int WIN_W      = 8,
  parameter bit SYNC_SPIKE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                spike_in,
  input  logic [WIN_W-1:0]    window_len,
  input  logic                clear,
  lif_spike_monitor_if.master out_if,
  output logic                overrun,
  output logic [7:0]          live_count
);

  typedef enum logic {CNT_IDLE, CNT_RUN} cnt_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_B0, OUT_B1, OUT_B2} out_state_t;

  cnt_state_t cnt_st, cnt_nxt;
  out_state_t out_st, out_nxt;

  logic             s, s_d, spk;
  logic [WIN_W-1:0] cyc;
  logic [7:0]       count, min_isi, last_isi, isi_cnt;
  logic             have_prev;
  logic [7:0]       rec_count, rec_min, rec_last;
  logic [7:0]       data_mux;
  logic             last_mux;

  generate
    if (SYNC_SPIKE) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       sync_q <= '0;
        else if (clear) sync_q <= '0;
        else            sync_q <= {sync_q[0], spike_in};
      end
      assign s = sync_q[1];
    end else begin : g_direct
      assign s = spike_in;
    end
  endgenerate

  assign spk = s & ~s_d;

  logic       run, active, win_end, spk_cnt, isi_hit, load;
  logic [7:0] isi, count_inc, min_upd, last_upd;

  assign run       = en && (window_len != '0);
  assign active    = (cnt_st == CNT_RUN) && run;
  // >= rather than == so a shortened window_len ends the window at once
  assign win_end   = active && (cyc >= window_len - WIN_W'(1));
  assign spk_cnt   = active && spk;
  assign isi       = isi_cnt + 8'd1;
  assign isi_hit   = spk_cnt && have_prev;
  assign count_inc = (spk_cnt && count != 8'hFF) ? count + 8'd1 : count;
  assign min_upd   = (isi_hit && isi < min_isi) ? isi : min_isi;
  assign last_upd  = isi_hit ? isi : last_isi;
  assign load      = win_end &&
                     ((out_st == OUT_IDLE) || (out_st == OUT_B2 && out_if.out_ready));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_st <= CNT_IDLE;
      out_st <= OUT_IDLE;
    end else begin
      cnt_st <= cnt_nxt;
      out_st <= out_nxt;
    end
  end

  always_comb begin
    cnt_nxt = cnt_st;
    case (cnt_st)
      CNT_IDLE: if (run)  cnt_nxt = CNT_RUN;
      CNT_RUN:  if (!run) cnt_nxt = CNT_IDLE;
      default:  cnt_nxt = CNT_IDLE;
    endcase
    if (clear) cnt_nxt = CNT_IDLE;
  end

  always_comb begin
    out_nxt  = out_st;
    data_mux = 8'h00;
    last_mux = 1'b0;
    case (out_st)
      OUT_IDLE: if (load) out_nxt = OUT_B0;
      OUT_B0: begin
        data_mux = rec_count;
        if (out_if.out_ready) out_nxt = OUT_B1;
      end
      OUT_B1: begin
        data_mux = rec_min;
        if (out_if.out_ready) out_nxt = OUT_B2;
      end
      OUT_B2: begin
        data_mux = rec_last;
        last_mux = 1'b1;
        if (out_if.out_ready) out_nxt = load ? OUT_B0 : OUT_IDLE;
      end
      default: out_nxt = OUT_IDLE;
    endcase
    if (clear) out_nxt = OUT_IDLE;
  end

  assign out_if.out_valid = (out_st != OUT_IDLE);
  assign out_if.out_data  = data_mux;
  assign out_if.out_last  = last_mux;
  assign live_count       = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_d       <= 1'b0;
      cyc       <= '0;
      count     <= 8'h00;
      min_isi   <= 8'hFF;
      last_isi  <= 8'h00;
      isi_cnt   <= 8'h00;
      have_prev <= 1'b0;
      rec_count <= 8'h00;
      rec_min   <= 8'h00;
      rec_last  <= 8'h00;
      overrun   <= 1'b0;
    end else if (clear) begin
      s_d       <= 1'b0;
      cyc       <= '0;
      count     <= 8'h00;
      min_isi   <= 8'hFF;
      last_isi  <= 8'h00;
      isi_cnt   <= 8'h00;
      have_prev <= 1'b0;
      rec_count <= 8'h00;
      rec_min   <= 8'h00;
      rec_last  <= 8'h00;
      overrun   <= 1'b0;
    end else begin
      s_d <= s;
      if (!active) begin
        cyc       <= '0;
        count     <= 8'h00;
        min_isi   <= 8'hFF;
        isi_cnt   <= 8'h00;
        have_prev <= 1'b0;
      end else begin
        have_prev <= have_prev | spk;
        isi_cnt   <= spk ? 8'h00 : ((isi_cnt == 8'd254) ? isi_cnt : isi_cnt + 8'd1);
        last_isi  <= last_upd;
        if (win_end) begin
          cyc     <= '0;
          count   <= 8'h00;
          min_isi <= 8'hFF;
        end else begin
          cyc     <= cyc + WIN_W'(1);
          count   <= count_inc;
          min_isi <= min_upd;
        end
      end
      // snapshot includes the window-end spike
      if (load) begin
        rec_count <= count_inc;
        rec_min   <= min_upd;
        rec_last  <= last_upd;
      end
      if (win_end && !load) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Bench for lif_spike_monitor: table vectors, directed corner sequences and random
// stimulus against a timestamp/queue reference model.
module tb_lif_spike_monitor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, spike_in, clear;
  logic [7:0] window_len;
  logic       overrun;
  logic [7:0] live_count;
  lif_spike_monitor_if bus();

  lif_spike_monitor #(.WIN_W(8), .SYNC_SPIKE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .window_len(window_len),
    .clear(clear), .out_if(bus.master), .overrun(overrun), .live_count(live_count));

  logic       en2, spike2, clear2;
  logic [9:0] wl2;
  logic       ovr2;
  logic [7:0] live2;
  lif_spike_monitor_if bus2();

  lif_spike_monitor #(.WIN_W(10), .SYNC_SPIKE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .spike_in(spike2), .window_len(wl2),
    .clear(clear2), .out_if(bus2.master), .overrun(ovr2), .live_count(live2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: spike timestamps for ISI, byte queue for the pending record
  bit m_sd, m_counting, m_overrun;
  int m_pos, m_count, m_min, m_last, m_prev_t, m_t;
  int exp_q[$];
  int got_q[$];

  function automatic void model_reset();
    m_sd = 0; m_counting = 0; m_overrun = 0;
    m_pos = 0; m_count = 0; m_min = 255; m_last = 0; m_prev_t = -1;
    exp_q.delete();
  endfunction

  function automatic void model_step(bit e, bit sp, int wl, bit clr, bit rdy);
    bit acc, edge_ev, run;
    int isi;
    m_t++;
    if (clr) begin
      model_reset();
      return;
    end
    acc = (exp_q.size() > 0) && rdy;
    edge_ev = sp && !m_sd;
    m_sd = sp;
    run = e && (wl != 0);
    if (acc) void'(exp_q.pop_front());
    if (m_counting && run) begin
      if (edge_ev) begin
        m_count = (m_count < 255) ? m_count + 1 : 255;
        if (m_prev_t >= 0) begin
          isi = m_t - m_prev_t;
          if (isi > 255) isi = 255;
          m_last = isi;
          if (isi < m_min) m_min = isi;
        end
        m_prev_t = m_t;
      end
      if (m_pos >= wl - 1) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(m_count);
          exp_q.push_back(m_min);
          exp_q.push_back(m_last);
        end else begin
          m_overrun = 1;
        end
        m_pos = 0; m_count = 0; m_min = 255;
      end else begin
        m_pos++;
      end
    end else begin
      m_pos = 0; m_count = 0; m_min = 255; m_prev_t = -1;
    end
    m_counting = run;
  endfunction

  task automatic cycle(input bit e, input bit sp, input int wl, input bit clr, input bit rdy);
    en = e; spike_in = sp; window_len = wl[7:0]; clear = clr; bus.out_ready = rdy;
    @(negedge clk);
    chk("out_valid", bus.out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("out_data", bus.out_data, exp_q[0]);
      chk("out_last", bus.out_last, exp_q.size() == 1);
    end
    chk("live_count", live_count, m_count);
    chk("overrun", overrun, m_overrun);
    if (bus.out_valid && rdy) got_q.push_back(int'(bus.out_data));
    model_step(e, sp, wl, clr, rdy);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int wl;
    int p0, p1, p2, p3;
    int width;
    int b0, b1, b2;
  } vec_t;

  vec_t vecs[6];

  function automatic bit spike_at(vec_t v, int k);
    bit r;
    r = 0;
    if (v.p0 >= 0 && k >= v.p0 && k < v.p0 + v.width) r = 1;
    if (v.p1 >= 0 && k >= v.p1 && k < v.p1 + v.width) r = 1;
    if (v.p2 >= 0 && k >= v.p2 && k < v.p2 + v.width) r = 1;
    if (v.p3 >= 0 && k >= v.p3 && k < v.p3 + v.width) r = 1;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops;
    int wl_r;
    int q2[$];

    vecs[0] = '{10,  2,   5,  9, -1,  1, 3,   3,   4};
    vecs[1] = '{8,   0,   7, -1, -1,  1, 2,   7,   7};
    vecs[2] = '{20,  3,  -1, -1, -1, 17, 1, 255,   0};
    vecs[3] = '{1,   0,  -1, -1, -1,  1, 1, 255,   0};
    vecs[4] = '{5,   0,   2,  4, -1,  1, 3,   2,   2};
    vecs[5] = '{255, 0, 254, -1, -1,  1, 2, 254, 254};

    en = 0; spike_in = 0; clear = 0; window_len = 8'd0; bus.out_ready = 0;
    en2 = 0; spike2 = 0; clear2 = 0; wl2 = 10'd0; bus2.out_ready = 0;
    m_t = 0;
    rst = 1;
    #2 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_live_count", live_count, 0);
    rst = 1;
    model_reset();

    // table vectors: one window, then drain with en low
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, vecs[i].wl, 1, 1);
      cycle(1, 0, vecs[i].wl, 0, 1);
      got_q.delete();
      for (int k = 0; k < vecs[i].wl; k++) cycle(1, spike_at(vecs[i], k), vecs[i].wl, 0, 1);
      for (int k = 0; k < 4; k++) cycle(0, 0, vecs[i].wl, 0, 1);
      chk("vec_nbytes", got_q.size(), 3);
      if (got_q.size() == 3) begin
        chk("vec_count", got_q[0], vecs[i].b0);
        chk("vec_min_isi", got_q[1], vecs[i].b1);
        chk("vec_last_isi", got_q[2], vecs[i].b2);
      end
    end

    // stalled consumer across two window ends, then clear
    cycle(1, 0, 4, 1, 0);
    cycle(1, 0, 4, 0, 0);
    for (int k = 0; k < 10; k++) cycle(1, k == 1, 4, 0, 0);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid_held", bus.out_valid, 1);
    chk("ovr_byte0_held", bus.out_data, 1);
    cycle(1, 0, 4, 1, 0);
    chk("clr_valid", bus.out_valid, 0);
    chk("clr_overrun", overrun, 0);
    chk("clr_live_count", live_count, 0);

    // ISI saturation and empty windows
    cycle(1, 0, 100, 1, 1);
    cycle(1, 0, 100, 0, 1);
    got_q.delete();
    for (int k = 0; k < 400; k++) cycle(1, (k == 50) || (k == 350), 100, 0, 1);
    for (int k = 0; k < 4; k++) cycle(0, 0, 100, 0, 1);
    chk("sat_nbytes", got_q.size(), 12);
    if (got_q.size() == 12) begin
      chk("empty_count", got_q[3], 0);
      chk("empty_min_isi", got_q[4], 255);
      chk("empty_last_isi", got_q[5], 0);
      chk("sat_count", got_q[9], 1);
      chk("sat_min_isi", got_q[10], 255);
      chk("sat_last_isi", got_q[11], 255);
    end

    // B2 accept coincides with window end
    cycle(1, 0, 4, 1, 1);
    cycle(1, 0, 4, 0, 1);
    drops = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1, (k % 4) == 1, 4, 0, (k % 4) != 0);
      if (k >= 3 && k < 19 && !bus.out_valid) drops++;
    end
    chk("b2_window_valid_drops", drops, 0);
    chk("b2_window_overrun", overrun, 0);

    // async reset in the middle of byte 1
    cycle(1, 0, 3, 1, 1);
    cycle(1, 0, 3, 0, 1);
    for (int k = 0; k < 3; k++) cycle(1, k == 0, 3, 0, 1);
    cycle(1, 0, 3, 0, 1);
    chk("midb1_valid", bus.out_valid, 1);
    chk("midb1_data", bus.out_data, 255);
    chk("midb1_last", bus.out_last, 0);
    rst = 0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_data", bus.out_data, 0);
    chk("async_rst_last", bus.out_last, 0);
    chk("async_rst_overrun", overrun, 0);
    chk("async_rst_live", live_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 3, 0, 1);
      chk("post_rst_valid", bus.out_valid, k == 3);
    end
    for (int k = 0; k < 4; k++) cycle(0, 0, 3, 0, 1);

    // random stimulus against the model
    wl_r = 6;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0)
        wl_r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      cycle($urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0, wl_r,
            $urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7);
    end

    // wide window, synchronized input, count saturation
    en2 = 1; wl2 = 10'd600; clear2 = 1; bus2.out_ready = 1; spike2 = 0;
    @(posedge clk);
    #1;
    clear2 = 0;
    for (int k = 0; k < 700 && q2.size() < 3; k++) begin
      @(negedge clk);
      if (bus2.out_valid && bus2.out_ready) q2.push_back(int'(bus2.out_data));
      @(posedge clk);
      #1;
      spike2 = ~spike2;
    end
    chk("wide_nbytes", q2.size(), 3);
    if (q2.size() == 3) begin
      chk("wide_count_sat", q2[0], 255);
      chk("wide_min_isi", q2[1], 2);
      chk("wide_last_isi", q2[2], 2);
    end
    en2 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
